// File: rtl/register_serializer.sv
// Parallel-in, serial-out converter with valid/ready on both sides and a done pulse per frame.
// Optional even-parity trailer beat when SERIALIZER_PARITY_EN is defined.
module register_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg_p0;
    logic [CW-1:0]     cnt_p0;
    logic              done_p1;
    logic              capture, beat, cnt_last, last_raw, frame_end;
`ifdef SERIALIZER_PARITY_EN
    logic              par_p0;
`endif

    function automatic logic head_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    // reset gates in_ready so nothing is captured while reset is held
    assign in_ready  = reset && enable && (state_q == IDLE);
    assign ser_valid = enable && (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign capture   = in_valid && in_ready;
    assign beat      = ser_valid && ser_ready;
    assign cnt_last  = (cnt_p0 == CW'(WIDTH - 1));
    assign last      = last_raw && enable;
    assign frame_end = beat && last_raw;
    assign done      = done_p1 && enable;

    always_comb begin
        state_d  = state_q;
        last_raw = 1'b0;
        ser_out  = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) state_d = SHIFT;
            end
            SHIFT: begin
                ser_out = head_bit(shreg_p0);
`ifdef SERIALIZER_PARITY_EN
                if (beat && cnt_last) state_d = PARITY;
`else
                last_raw = cnt_last;
                if (beat && cnt_last) state_d = IDLE;
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                ser_out  = par_p0;
                last_raw = 1'b1;
                if (beat) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // control: state, beat count, done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_p0  <= '0;
            done_p1 <= 1'b0;
        end else if (enable) begin
            state_q <= state_d;
            done_p1 <= frame_end;
            if (capture)
                cnt_p0 <= '0;
            else if (beat && state_q == SHIFT)
                cnt_p0 <= cnt_p0 + CW'(1);
        end
    end

    // data: shift register (and parity) need no reset, outputs are gated by state
    always_ff @(posedge clk) begin
        if (enable) begin
            if (capture) begin
                shreg_p0 <= in;
`ifdef SERIALIZER_PARITY_EN
                par_p0   <= ^in;
`endif
            end else if (beat && state_q == SHIFT) begin
                shreg_p0 <= advance(shreg_p0);
            end
        end
    end

endmodule
